// File: rtl/softmax_scheduler_if.sv
// Handshake and bus bundle between the output neuron layer, softmax_unit and the
// result consumer. master is the scheduler's view, slave is the surrounding system.
interface softmax_scheduler_if #(
    parameter int N_CLASSES = 10,
    parameter int DW        = 16
);
    logic                    nv_valid;
    logic                    nv_ready;
    logic [DW-1:0]           nv_data;
    logic                    nv_last;
    logic [N_CLASSES*DW-1:0] sm_neurons;
    logic                    sm_in_valid;
    logic [N_CLASSES*DW-1:0] sm_softmax;
    logic                    sm_out_valid;
    logic                    res_valid;
    logic                    res_ready;
    logic [N_CLASSES*DW-1:0] res_probs;
    logic [3:0]              res_class;
    logic [DW-1:0]           res_max;
    logic                    busy;
    logic                    err_frame;
    logic                    err_timeout;

    modport master (
        input  nv_valid, nv_data, nv_last, sm_softmax, sm_out_valid, res_ready,
        output nv_ready, sm_neurons, sm_in_valid, res_valid, res_probs, res_class,
               res_max, busy, err_frame, err_timeout
    );

    modport slave (
        output nv_valid, nv_data, nv_last, sm_softmax, sm_out_valid, res_ready,
        input  nv_ready, sm_neurons, sm_in_valid, res_valid, res_probs, res_class,
               res_max, busy, err_frame, err_timeout
    );
endinterface

// File: rtl/softmax_scheduler.sv
// Frame collector, softmax launcher and sequential argmax. Valid/ready rule on
// nv_* and res_*: a transfer happens on a rising edge where valid && ready are both 1.
module softmax_scheduler #(
    parameter int N_CLASSES = 10,
    parameter int DW        = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    softmax_scheduler_if.master bus,
    output logic [2:0]          dbg_state
);
    localparam int CW = $clog2(N_CLASSES);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_CLASSES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_DRAIN   = 3'd1,
        S_LAUNCH  = 3'd2,
        S_WAIT    = 3'd3,
        S_ARGMAX  = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           arg_i;
    logic [TW-1:0]           wait_cnt;
    logic [N_CLASSES*DW-1:0] frame;
    logic [N_CLASSES*DW-1:0] probs;
    logic [3:0]              best_idx;
    logic [DW-1:0]           best_val;
    logic [DW-1:0]           cand;
    logic                    err_frame_q;
    logic                    beat_acc;
    logic                    short_frame;
    logic                    long_frame;
    logic                    timed_out;

    always_comb begin
        state_nx    = state;
        short_frame = 1'b0;
        long_frame  = 1'b0;
        timed_out   = 1'b0;
        beat_acc    = bus.nv_valid && (state == S_COLLECT || state == S_DRAIN);
        case (state)
            S_COLLECT: begin
                if (beat_acc) begin
                    if (cnt == LAST_IDX) begin
                        if (bus.nv_last) begin
                            state_nx = S_LAUNCH;
                        end else begin
                            long_frame = 1'b1;
                            state_nx   = S_DRAIN;
                        end
                    end else if (bus.nv_last) begin
                        short_frame = 1'b1;
                    end
                end
            end
            S_DRAIN:  if (beat_acc && bus.nv_last) state_nx = S_COLLECT;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT: begin
                if (bus.sm_out_valid) begin
                    state_nx = S_ARGMAX;
                end else if (wait_cnt == TO_LAST) begin
                    timed_out = 1'b1;
                    state_nx  = S_COLLECT;
                end
            end
            S_ARGMAX: if (arg_i == LAST_IDX) state_nx = S_HOLD;
            S_HOLD:   if (bus.res_ready) state_nx = S_COLLECT;
            default:  state_nx = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_COLLECT;
        else        state <= state_nx;
    end

    // Element under test this ARGMAX cycle; index 0 seeds the running max.
    assign cand = probs[int'(arg_i)*DW +: DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            arg_i       <= '0;
            wait_cnt    <= '0;
            frame       <= '0;
            probs       <= '0;
            best_idx    <= '0;
            best_val    <= '0;
            err_frame_q <= 1'b0;
        end else begin
            err_frame_q <= short_frame || long_frame;
            case (state)
                S_COLLECT: begin
                    if (beat_acc) begin
                        frame[int'(cnt)*DW +: DW] <= bus.nv_data;
                        if (short_frame || cnt == LAST_IDX) cnt <= '0;
                        else                                cnt <= cnt + 1'b1;
                    end
                end
                S_LAUNCH: wait_cnt <= '0;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (bus.sm_out_valid) begin
                        probs <= bus.sm_softmax;
                        arg_i <= '0;
                    end
                end
                S_ARGMAX: begin
                    // Strictly greater keeps the lowest index on ties.
                    if (arg_i == '0 || cand > best_val) begin
                        best_val <= cand;
                        best_idx <= 4'(arg_i);
                    end
                    arg_i <= arg_i + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // nv_ready is gated by rst_n so every output reads 0 while reset is held.
    assign bus.nv_ready    = rst_n && (state == S_COLLECT || state == S_DRAIN);
    assign bus.sm_in_valid = (state == S_LAUNCH);
    assign bus.sm_neurons  = frame;
    assign bus.res_valid   = (state == S_HOLD);
    assign bus.res_probs   = probs;
    assign bus.res_class   = best_idx;
    assign bus.res_max     = best_val;
    assign bus.busy        = !(state == S_COLLECT && cnt == '0);
    assign bus.err_frame   = err_frame_q;
    assign bus.err_timeout = timed_out;
    assign dbg_state       = state;
endmodule

// File: tb/tb_softmax_scheduler.sv
// Directed bench for softmax_scheduler: frames, argmax cases, frame errors,
// timeout, backpressure and asynchronous reset.
module tb_softmax_scheduler;
    localparam int N       = 10;
    localparam int DW      = 16;
    localparam int TIMEOUT = 255;
    localparam logic [2:0] ST_COLLECT = 3'd0;
    localparam logic [2:0] ST_DRAIN   = 3'd1;
    localparam logic [2:0] ST_LAUNCH  = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_ARGMAX  = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;
    int checks = 0;
    int failures = 0;
    int launch_cnt = 0;
    int errf_cnt = 0;
    int errt_cnt = 0;
    int overlap_cnt = 0;

    softmax_scheduler_if #(.N_CLASSES(N), .DW(DW)) sif ();

    softmax_scheduler #(.N_CLASSES(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (sif.master),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sif.sm_in_valid) launch_cnt <= launch_cnt + 1;
        if (sif.err_frame) errf_cnt <= errf_cnt + 1;
        if (sif.err_timeout) errt_cnt <= errt_cnt + 1;
        if ((sif.err_frame || sif.err_timeout) && sif.res_valid) overlap_cnt <= overlap_cnt + 1;
    end

    // Drivers (called #1 after a rising edge)
    task automatic send_beat(input logic [DW-1:0] d, input logic last, output int stall);
        sif.nv_valid = 1'b1;
        sif.nv_data  = d;
        sif.nv_last  = last;
        stall = 0;
        while (!sif.nv_ready && stall < 400) begin
            @(posedge clk); #1;
            stall++;
        end
        @(posedge clk); #1;
    endtask

    task automatic nv_idle();
        sif.nv_valid = 1'b0;
        sif.nv_last  = 1'b0;
        sif.nv_data  = '0;
    endtask

    task automatic send_frame(input int nbeats, input int last_idx, output int stalls);
        int st;
        stalls = 0;
        for (int i = 0; i < nbeats; i++) begin
            send_beat(DW'((i + 1) * 100), (i == last_idx), st);
            stalls += st;
        end
        nv_idle();
    endtask

    task automatic respond(input logic [N*DW-1:0] p, input int lat);
        repeat (lat) begin @(posedge clk); #1; end
        sif.sm_softmax   = p;
        sif.sm_out_valid = 1'b1;
        @(posedge clk); #1;
        sif.sm_out_valid = 1'b0;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!sif.res_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic handshake();
        sif.res_ready = 1'b1;
        @(posedge clk); #1;
        sif.res_ready = 1'b0;
    endtask

    function automatic logic [N*DW-1:0] ramp_probs();
        logic [N*DW-1:0] p;
        for (int i = 0; i < N; i++) p[i*DW +: DW] = DW'(i * 256);
        return p;
    endfunction

    // Tests
    task automatic test_reset();
        nv_idle();
        sif.sm_softmax = '0; sif.sm_out_valid = 1'b0; sif.res_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sif.nv_ready !== 1'b0) begin failures++; $display("FAIL rst_nv_ready got=%b exp=0", sif.nv_ready); end
        checks++; if (sif.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", sif.busy); end
        checks++; if (sif.sm_in_valid !== 1'b0) begin failures++; $display("FAIL rst_sm_in_valid got=%b exp=0", sif.sm_in_valid); end
        checks++; if (sif.res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", sif.res_valid); end
        checks++; if (sif.sm_neurons !== '0) begin failures++; $display("FAIL rst_sm_neurons got=%h exp=0", sif.sm_neurons); end
        checks++; if (sif.res_probs !== '0) begin failures++; $display("FAIL rst_res_probs got=%h exp=0", sif.res_probs); end
        checks++; if ({sif.res_class, sif.res_max} !== '0) begin failures++; $display("FAIL rst_res got=%h/%h exp=0", sif.res_class, sif.res_max); end
        checks++; if ({sif.err_frame, sif.err_timeout} !== 2'b00) begin failures++; $display("FAIL rst_err got=%b exp=00", {sif.err_frame, sif.err_timeout}); end
        checks++; if (dbg_state !== ST_COLLECT) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_COLLECT); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (sif.nv_ready !== 1'b1) begin failures++; $display("FAIL rst_rel_nv_ready got=%b exp=1", sif.nv_ready); end
        checks++; if (sif.busy !== 1'b0) begin failures++; $display("FAIL rst_rel_busy got=%b exp=0", sif.busy); end
    endtask

    task automatic test_normal();
        int st, n, l0;
        logic [N*DW-1:0] p;
        l0 = launch_cnt;
        send_frame(10, 9, st);
        checks++; if (st !== 0) begin failures++; $display("FAIL norm_stall got=%0d exp=0", st); end
        checks++; if (dbg_state !== ST_LAUNCH) begin failures++; $display("FAIL norm_launch_state got=%0d exp=%0d", dbg_state, ST_LAUNCH); end
        checks++; if (sif.sm_in_valid !== 1'b1) begin failures++; $display("FAIL norm_sm_in_valid got=%b exp=1", sif.sm_in_valid); end
        checks++; if (sif.sm_neurons[7*DW +: DW] !== 16'd800) begin failures++; $display("FAIL norm_neuron7 got=%0d exp=800", sif.sm_neurons[7*DW +: DW]); end
        checks++; if (sif.sm_neurons[0 +: DW] !== 16'd100) begin failures++; $display("FAIL norm_neuron0 got=%0d exp=100", sif.sm_neurons[0 +: DW]); end
        checks++; if (sif.sm_neurons[9*DW +: DW] !== 16'd1000) begin failures++; $display("FAIL norm_neuron9 got=%0d exp=1000", sif.sm_neurons[9*DW +: DW]); end
        checks++; if ({sif.busy, sif.nv_ready} !== 2'b10) begin failures++; $display("FAIL norm_busy_ready got=%b exp=10", {sif.busy, sif.nv_ready}); end
        @(posedge clk); #1;
        checks++; if (sif.sm_in_valid !== 1'b0) begin failures++; $display("FAIL norm_launch_pulse got=%b exp=0", sif.sm_in_valid); end
        checks++; if (dbg_state !== ST_WAIT) begin failures++; $display("FAIL norm_wait_state got=%0d exp=%0d", dbg_state, ST_WAIT); end
        p = ramp_probs();
        p[7*DW +: DW] = 16'h4000;
        respond(p, 21);
        checks++; if (sif.res_probs !== p) begin failures++; $display("FAIL norm_probs_capture got=%h exp=%h", sif.res_probs, p); end
        checks++; if (sif.sm_neurons[3*DW +: DW] !== 16'd400) begin failures++; $display("FAIL norm_neuron_hold got=%0d exp=400", sif.sm_neurons[3*DW +: DW]); end
        checks++; if (dbg_state !== ST_ARGMAX) begin failures++; $display("FAIL norm_argmax_state got=%0d exp=%0d", dbg_state, ST_ARGMAX); end
        wait_res(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL norm_res_latency got=%0d exp=10", n); end
        checks++; if (sif.res_class !== 4'd7) begin failures++; $display("FAIL norm_class got=%0d exp=7", sif.res_class); end
        checks++; if (sif.res_max !== 16'h4000) begin failures++; $display("FAIL norm_max got=%h exp=4000", sif.res_max); end
        checks++; if (launch_cnt - l0 !== 1) begin failures++; $display("FAIL norm_launch_count got=%0d exp=1", launch_cnt - l0); end
        handshake();
        checks++; if (sif.res_valid !== 1'b0) begin failures++; $display("FAIL norm_res_drop got=%b exp=0", sif.res_valid); end
        checks++; if (sif.nv_ready !== 1'b1) begin failures++; $display("FAIL norm_next_ready got=%b exp=1", sif.nv_ready); end
    endtask

    task automatic test_short_frame();
        int st, l0, e0;
        l0 = launch_cnt;
        e0 = errf_cnt;
        send_frame(5, 4, st);
        checks++; if (sif.err_frame !== 1'b1) begin failures++; $display("FAIL short_err got=%b exp=1", sif.err_frame); end
        checks++; if (dbg_state !== ST_COLLECT) begin failures++; $display("FAIL short_state got=%0d exp=%0d", dbg_state, ST_COLLECT); end
        checks++; if (sif.busy !== 1'b0) begin failures++; $display("FAIL short_busy got=%b exp=0", sif.busy); end
        @(posedge clk); #1;
        checks++; if (sif.err_frame !== 1'b0) begin failures++; $display("FAIL short_err_pulse got=%b exp=0", sif.err_frame); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (launch_cnt !== l0) begin failures++; $display("FAIL short_no_launch got=%0d exp=%0d", launch_cnt, l0); end
        checks++; if (errf_cnt - e0 !== 1) begin failures++; $display("FAIL short_err_count got=%0d exp=1", errf_cnt - e0); end
    endtask

    task automatic test_tie();
        int st, n;
        logic [N*DW-1:0] p;
        send_frame(10, 9, st);
        checks++; if (sif.sm_in_valid !== 1'b1) begin failures++; $display("FAIL tie_launch got=%b exp=1", sif.sm_in_valid); end
        checks++; if (sif.sm_neurons[4*DW +: DW] !== 16'd500) begin failures++; $display("FAIL tie_neuron4 got=%0d exp=500", sif.sm_neurons[4*DW +: DW]); end
        p = ramp_probs();
        p[2*DW +: DW] = 16'h3000;
        p[5*DW +: DW] = 16'h3000;
        respond(p, 22);
        wait_res(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL tie_latency got=%0d exp=10", n); end
        checks++; if (sif.res_class !== 4'd2) begin failures++; $display("FAIL tie_class got=%0d exp=2", sif.res_class); end
        checks++; if (sif.res_max !== 16'h3000) begin failures++; $display("FAIL tie_max got=%h exp=3000", sif.res_max); end
        handshake();
    endtask

    task automatic test_boundary_probs();
        int st, n;
        logic [N*DW-1:0] p;
        // Top bit set on the last element: only an unsigned compare picks it.
        send_frame(10, 9, st);
        for (int i = 0; i < N; i++) p[i*DW +: DW] = 16'h7FFF;
        p[9*DW +: DW] = 16'h8000;
        respond(p, 5);
        wait_res(n);
        checks++; if (sif.res_class !== 4'd9) begin failures++; $display("FAIL bnd_last_class got=%0d exp=9", sif.res_class); end
        checks++; if (sif.res_max !== 16'h8000) begin failures++; $display("FAIL bnd_last_max got=%h exp=8000", sif.res_max); end
        handshake();
        send_frame(10, 9, st);
        for (int i = 0; i < N; i++) p[i*DW +: DW] = 16'h1234;
        respond(p, 3);
        wait_res(n);
        checks++; if (sif.res_class !== 4'd0) begin failures++; $display("FAIL bnd_equal_class got=%0d exp=0", sif.res_class); end
        checks++; if (sif.res_max !== 16'h1234) begin failures++; $display("FAIL bnd_equal_max got=%h exp=1234", sif.res_max); end
        handshake();
    endtask

    task automatic test_long_frame();
        int st, stalls, l0, e0;
        l0 = launch_cnt;
        e0 = errf_cnt;
        stalls = 0;
        for (int i = 0; i < 13; i++) begin
            send_beat(DW'(i + 1), (i == 12), st);
            stalls += st;
            if (i == 9) begin
                checks++; if (sif.err_frame !== 1'b1) begin failures++; $display("FAIL long_err got=%b exp=1", sif.err_frame); end
                checks++; if (dbg_state !== ST_DRAIN) begin failures++; $display("FAIL long_drain_state got=%0d exp=%0d", dbg_state, ST_DRAIN); end
                checks++; if (sif.nv_ready !== 1'b1) begin failures++; $display("FAIL long_drain_ready got=%b exp=1", sif.nv_ready); end
            end
        end
        nv_idle();
        checks++; if (stalls !== 0) begin failures++; $display("FAIL long_stalls got=%0d exp=0", stalls); end
        checks++; if (dbg_state !== ST_COLLECT) begin failures++; $display("FAIL long_end_state got=%0d exp=%0d", dbg_state, ST_COLLECT); end
        checks++; if (sif.busy !== 1'b0) begin failures++; $display("FAIL long_busy got=%b exp=0", sif.busy); end
        @(posedge clk); #1;
        checks++; if (launch_cnt !== l0) begin failures++; $display("FAIL long_no_launch got=%0d exp=%0d", launch_cnt, l0); end
        checks++; if (errf_cnt - e0 !== 1) begin failures++; $display("FAIL long_err_count got=%0d exp=1", errf_cnt - e0); end
    endtask

    task automatic test_timeout();
        int st, k;
        send_frame(10, 9, st);
        k = 0;
        while (!sif.err_timeout && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        checks++; if (k !== TIMEOUT) begin failures++; $display("FAIL to_cycle got=%0d exp=%0d", k, TIMEOUT); end
        checks++; if (dbg_state !== ST_WAIT) begin failures++; $display("FAIL to_state got=%0d exp=%0d", dbg_state, ST_WAIT); end
        @(posedge clk); #1;
        checks++; if (sif.err_timeout !== 1'b0) begin failures++; $display("FAIL to_pulse got=%b exp=0", sif.err_timeout); end
        checks++; if (dbg_state !== ST_COLLECT) begin failures++; $display("FAIL to_recover got=%0d exp=%0d", dbg_state, ST_COLLECT); end
        checks++; if ({sif.nv_ready, sif.busy} !== 2'b10) begin failures++; $display("FAIL to_ready_busy got=%b exp=10", {sif.nv_ready, sif.busy}); end
        // A late done pulse outside WAIT must be ignored.
        sif.sm_softmax = ramp_probs();
        sif.sm_out_valid = 1'b1;
        @(posedge clk); #1;
        sif.sm_out_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (dbg_state !== ST_COLLECT) begin failures++; $display("FAIL to_late_state got=%0d exp=%0d", dbg_state, ST_COLLECT); end
        checks++; if (sif.res_valid !== 1'b0) begin failures++; $display("FAIL to_late_res got=%b exp=0", sif.res_valid); end
    endtask

    task automatic test_backpressure();
        int st, n;
        logic [N*DW-1:0] p;
        send_frame(10, 9, st);
        p = ramp_probs();
        p[3*DW +: DW] = 16'h5555;
        respond(p, 22);
        wait_res(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL bp_latency got=%0d exp=10", n); end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++; if (sif.res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, sif.res_valid); end
            checks++; if (sif.res_class !== 4'd3) begin failures++; $display("FAIL bp_class c=%0d got=%0d exp=3", c, sif.res_class); end
            checks++; if (sif.res_max !== 16'h5555) begin failures++; $display("FAIL bp_max c=%0d got=%h exp=5555", c, sif.res_max); end
            checks++; if (sif.res_probs !== p) begin failures++; $display("FAIL bp_probs c=%0d got=%h exp=%h", c, sif.res_probs, p); end
            checks++; if (sif.nv_ready !== 1'b0) begin failures++; $display("FAIL bp_nv_ready c=%0d got=%b exp=0", c, sif.nv_ready); end
        end
        handshake();
        checks++; if (sif.nv_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", sif.nv_ready); end
    endtask

    task automatic test_back_to_back();
        int st, n;
        logic [N*DW-1:0] p;
        send_frame(10, 9, st);
        p = ramp_probs();
        p[1*DW +: DW] = 16'h6000;
        respond(p, 10);
        wait_res(n);
        checks++; if (sif.res_class !== 4'd1) begin failures++; $display("FAIL b2b_class_a got=%0d exp=1", sif.res_class); end
        handshake();
        send_frame(10, 9, st);
        checks++; if (st !== 0) begin failures++; $display("FAIL b2b_stall got=%0d exp=0", st); end
        checks++; if (sif.sm_in_valid !== 1'b1) begin failures++; $display("FAIL b2b_launch got=%b exp=1", sif.sm_in_valid); end
        p = ramp_probs();
        p[8*DW +: DW] = 16'h7000;
        respond(p, 10);
        wait_res(n);
        checks++; if (sif.res_class !== 4'd8) begin failures++; $display("FAIL b2b_class_b got=%0d exp=8", sif.res_class); end
        checks++; if (sif.res_max !== 16'h7000) begin failures++; $display("FAIL b2b_max_b got=%h exp=7000", sif.res_max); end
        handshake();
    endtask

    task automatic test_async_reset();
        int st, n;
        send_frame(10, 9, st);
        repeat (5) @(posedge clk);
        #2;
        checks++; if (dbg_state !== ST_WAIT) begin failures++; $display("FAIL ar_pre_state got=%0d exp=%0d", dbg_state, ST_WAIT); end
        rst_n = 1'b0;
        #1;
        checks++; if (dbg_state !== ST_COLLECT) begin failures++; $display("FAIL ar_state got=%0d exp=%0d", dbg_state, ST_COLLECT); end
        checks++; if ({sif.nv_ready, sif.busy, sif.sm_in_valid, sif.res_valid} !== 4'b0000) begin failures++; $display("FAIL ar_flags got=%b exp=0000", {sif.nv_ready, sif.busy, sif.sm_in_valid, sif.res_valid}); end
        checks++; if (sif.sm_neurons !== '0) begin failures++; $display("FAIL ar_sm_neurons got=%h exp=0", sif.sm_neurons); end
        checks++; if (sif.res_probs !== '0) begin failures++; $display("FAIL ar_res_probs got=%h exp=0", sif.res_probs); end
        checks++; if ({sif.res_class, sif.res_max} !== '0) begin failures++; $display("FAIL ar_res got=%h/%h exp=0", sif.res_class, sif.res_max); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (sif.nv_ready !== 1'b1) begin failures++; $display("FAIL ar_release_ready got=%b exp=1", sif.nv_ready); end
        send_frame(10, 9, st);
        respond(ramp_probs(), 22);
        wait_res(n);
        checks++; if (sif.res_class !== 4'd9) begin failures++; $display("FAIL ar_recover_class got=%0d exp=9", sif.res_class); end
        checks++; if (sif.res_max !== 16'h0900) begin failures++; $display("FAIL ar_recover_max got=%h exp=0900", sif.res_max); end
        handshake();
    endtask

    task automatic test_totals();
        checks++; if (overlap_cnt !== 0) begin failures++; $display("FAIL err_res_overlap got=%0d exp=0", overlap_cnt); end
        checks++; if (errt_cnt !== 1) begin failures++; $display("FAIL timeout_total got=%0d exp=1", errt_cnt); end
        checks++; if (errf_cnt !== 2) begin failures++; $display("FAIL frame_err_total got=%0d exp=2", errf_cnt); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_short_frame();
        test_tie();
        test_boundary_probs();
        test_long_frame();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_totals();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
